// File: rtl/vga_pkg.sv
// vga_pkg: video timing constants shared by the pixel-pipeline blocks.
//   H_ACTIVE / V_ACTIVE : active pixels per line / active lines per frame
//   PIX_W               : grayscale pixel width
//   COORD_W             : width of the x/y pixel coordinate buses
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PIX_W    = 12;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Address width for a memory of 'depth' entries (never below 1 bit).
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: simple dual-port RAM, one read port and one write port on the
// same clock, synchronous read, read-first (a read and a write to the same
// address in one cycle return the old word). Contents are never reset.
//   clk     : clock
//   rd_en   : read enable; rd_data updates on the next rising edge
//   rd_addr : read address
//   rd_data : registered read data
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both accesses are non-blocking in one block, so the read sees the word
  // as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: builds a 3x3 grayscale neighbourhood from a raster pixel
// stream using two line buffers. The window covers columns x-2..x and lines
// y-2..y of the pixel presented two pclk cycles earlier.
//   pclk, reset_n              : clock, asynchronous active-low reset
//   DE_s1                      : pixel valid this cycle
//   x_pixel_s1, y_pixel_s1     : coordinates of the incoming pixel
//   gray_s1                    : incoming grayscale pixel
//   data_rc_s3_g (r,c in 0..2) : window taps, row r = line y-2+r,
//                                column c = x-2+c; registered outputs
//
// Stream semantics: DE_s1 is a valid-only qualifier with no backpressure;
// a pixel is consumed in every cycle where DE_s1=1 and x_pixel_s1<H_ACTIVE,
// any other cycle is a bubble that leaves all state untouched.
module window_3x3_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int PIX_W    = vga_pkg::PIX_W
) (
  input  logic                        pclk,
  input  logic                        reset_n,
  input  logic                        DE_s1,
  input  logic [vga_pkg::COORD_W-1:0] x_pixel_s1,
  input  logic [vga_pkg::COORD_W-1:0] y_pixel_s1,
  input  logic [PIX_W-1:0]            gray_s1,
  output logic [PIX_W-1:0]            data_00_s3_g,
  output logic [PIX_W-1:0]            data_01_s3_g,
  output logic [PIX_W-1:0]            data_02_s3_g,
  output logic [PIX_W-1:0]            data_10_s3_g,
  output logic [PIX_W-1:0]            data_11_s3_g,
  output logic [PIX_W-1:0]            data_12_s3_g,
  output logic [PIX_W-1:0]            data_20_s3_g,
  output logic [PIX_W-1:0]            data_21_s3_g,
  output logic [PIX_W-1:0]            data_22_s3_g
);

  localparam int ADDR_W = vga_pkg::addr_w(H_ACTIVE);

  // Stage 1: qualify the pixel; out-of-range columns behave as DE=0.
  logic              accept_s1;
  logic [ADDR_W-1:0] addr_s1;

  assign accept_s1 = DE_s1 && (32'(x_pixel_s1) < 32'(H_ACTIVE));
  assign addr_s1   = x_pixel_s1[ADDR_W-1:0];

  // Stage 2 registers
  logic                  de_s2;
  vga_pkg::coord_t       x_s2;
  vga_pkg::coord_t       y_s2;
  logic [PIX_W-1:0]      gray_s2;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      de_s2   <= 1'b0;
      x_s2    <= '0;
      y_s2    <= '0;
      gray_s2 <= '0;
    end else begin
      de_s2   <= accept_s1;
      x_s2    <= x_pixel_s1;
      y_s2    <= y_pixel_s1;
      gray_s2 <= gray_s1;
    end
  end

  // LB0 holds line y-1, LB1 holds line y-2. The word leaving LB0 in stage 2
  // is exactly what LB1 needs at the same column, so it is copied across one
  // cycle after the read.
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  line_buffer #(.DEPTH(H_ACTIVE), .DATA_W(PIX_W), .ADDR_W(ADDR_W)) u_lb0 (
    .clk     (pclk),
    .rd_en   (accept_s1),
    .rd_addr (addr_s1),
    .rd_data (lb0_rd),
    .wr_en   (accept_s1),
    .wr_addr (addr_s1),
    .wr_data (gray_s1)
  );

  line_buffer #(.DEPTH(H_ACTIVE), .DATA_W(PIX_W), .ADDR_W(ADDR_W)) u_lb1 (
    .clk     (pclk),
    .rd_en   (accept_s1),
    .rd_addr (addr_s1),
    .rd_data (lb1_rd),
    .wr_en   (de_s2),
    .wr_addr (x_s2[ADDR_W-1:0]),
    .wr_data (lb0_rd)
  );

  // New rightmost column, with lines above the frame forced to zero. This
  // masking is also what hides stale line-buffer content at frame start.
  logic [PIX_W-1:0] new_col [3];

  always_comb begin
    new_col[0] = (y_s2 < vga_pkg::coord_t'(2)) ? '0 : lb1_rd;
    new_col[1] = (y_s2 == '0)                  ? '0 : lb0_rd;
    new_col[2] = gray_s2;
  end

  // Window registers win[row][col]; col 2 is the newest column.
  logic [PIX_W-1:0] win [3][3];

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (de_s2) begin
      for (int r = 0; r < 3; r++) begin
        if (x_s2 == '0) begin
          // Columns left of the frame read as zero.
          win[r][0] <= '0;
          win[r][1] <= '0;
        end else begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[r][2] <= new_col[r];
      end
    end
  end

  assign data_00_s3_g = win[0][0];
  assign data_01_s3_g = win[0][1];
  assign data_02_s3_g = win[0][2];
  assign data_10_s3_g = win[1][0];
  assign data_11_s3_g = win[1][1];
  assign data_12_s3_g = win[1][2];
  assign data_20_s3_g = win[2][0];
  assign data_21_s3_g = win[2][1];
  assign data_22_s3_g = win[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: self-checking bench for window_3x3_gen. A reference
// model keeps, per column, the two most recent pixels written there and the
// list of columns accepted since the start of the current line; the
// expected window is the last three entries of that list.
module tb_window_3x3_gen;

  localparam int PW = 12;
  localparam int HA = 640;

  typedef logic [8:0][PW-1:0] win_t;  // index r*3+c

  // Clock / reset / DUT signals
  logic          pclk = 1'b0;
  logic          reset_n;
  logic          DE_s1;
  logic [9:0]    x_pixel_s1;
  logic [9:0]    y_pixel_s1;
  logic [PW-1:0] gray_s1;
  logic [PW-1:0] data_00_s3_g, data_01_s3_g, data_02_s3_g;
  logic [PW-1:0] data_10_s3_g, data_11_s3_g, data_12_s3_g;
  logic [PW-1:0] data_20_s3_g, data_21_s3_g, data_22_s3_g;

  always #5 pclk = ~pclk;

  window_3x3_gen #(.H_ACTIVE(HA), .PIX_W(PW)) dut (
    .pclk         (pclk),
    .reset_n      (reset_n),
    .DE_s1        (DE_s1),
    .x_pixel_s1   (x_pixel_s1),
    .y_pixel_s1   (y_pixel_s1),
    .gray_s1      (gray_s1),
    .data_00_s3_g (data_00_s3_g),
    .data_01_s3_g (data_01_s3_g),
    .data_02_s3_g (data_02_s3_g),
    .data_10_s3_g (data_10_s3_g),
    .data_11_s3_g (data_11_s3_g),
    .data_12_s3_g (data_12_s3_g),
    .data_20_s3_g (data_20_s3_g),
    .data_21_s3_g (data_21_s3_g),
    .data_22_s3_g (data_22_s3_g)
  );

  // Reference model state
  logic [PW-1:0]   last1 [HA];   // most recent pixel written at column x
  logic [PW-1:0]   last2 [HA];   // the one before that
  logic [3*PW-1:0] cols [$];     // {row0,row1,row2} per accepted column
  win_t            exp_now;      // expected DUT window after the last edge

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [PW-1:0] ramp(input int x, input int y);
    return PW'(x + y);
  endfunction

  function automatic win_t model_window();
    win_t w;
    logic [3*PW-1:0] col;
    for (int c = 0; c < 3; c++) begin
      col = cols[cols.size() - 3 + c];
      w[c]     = col[3*PW-1:2*PW];
      w[3 + c] = col[2*PW-1:PW];
      w[6 + c] = col[PW-1:0];
    end
    return w;
  endfunction

  function automatic win_t dut_window();
    win_t w;
    w[0] = data_00_s3_g; w[1] = data_01_s3_g; w[2] = data_02_s3_g;
    w[3] = data_10_s3_g; w[4] = data_11_s3_g; w[5] = data_12_s3_g;
    w[6] = data_20_s3_g; w[7] = data_21_s3_g; w[8] = data_22_s3_g;
    return w;
  endfunction

  task automatic model_reset();
    cols.delete();
    repeat (3) cols.push_back('0);
  endtask

  // A pixel joins the window with the two older pixels of its column above
  // it; lines above the frame and columns left of the line are zero.
  task automatic model_accept(input int x, input int y, input logic [PW-1:0] g);
    logic [PW-1:0] r0, r1;
    r0 = (y <= 1) ? '0 : last2[x];
    r1 = (y == 0) ? '0 : last1[x];
    last2[x] = last1[x];
    last1[x] = g;
    if (x == 0) begin
      cols.push_back('0);
      cols.push_back('0);
    end
    cols.push_back({r0, r1, g});
    while (cols.size() > 3) void'(cols.pop_front());
  endtask

  // Drive one cycle. After the edge, exp_now holds the window the DUT must
  // show (everything accepted before this cycle), then this pixel is added.
  task automatic step(input logic de, input int x, input int y, input logic [PW-1:0] g);
    DE_s1      = de;
    x_pixel_s1 = x[9:0];
    y_pixel_s1 = y[9:0];
    gray_s1    = g;
    @(posedge pclk);
    #1;
    exp_now = model_window();
    if (de && x < HA && reset_n) model_accept(x, y, g);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    DE_s1 = 1'b0; x_pixel_s1 = '0; y_pixel_s1 = '0; gray_s1 = '0;
    model_reset();
    for (int x = 0; x < HA; x++) begin
      last1[x] = '0;
      last2[x] = '0;
    end
    repeat (3) @(posedge pclk);
    #1;
    n_checks++;
    if (dut_window() !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected 0", dut_window());
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 0, '0);
      n_checks++;
      if (dut_window() !== exp_now) begin
        n_errors++;
        $display("FAIL post_reset_idle: got %h expected %h", dut_window(), exp_now);
      end
    end
  endtask

  task automatic test_ramp_frame();
    win_t e;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < HA; x++) begin
        step(1'b1, x, y, ramp(x, y));
        n_checks++;
        if (dut_window() !== exp_now) begin
          n_errors++;
          $display("FAIL ramp_model y=%0d x=%0d: got %h expected %h", y, x, dut_window(), exp_now);
        end
        // Window for pixel (3,0) is visible one step later.
        if (y == 0 && x == 4) begin
          e = '0; e[6] = 12'd1; e[7] = 12'd2; e[8] = 12'd3;
          n_checks++;
          if (dut_window() !== e) begin
            n_errors++;
            $display("FAIL top_edge: got %h expected %h", dut_window(), e);
          end
        end
        if (y == 2 && x == 6) begin
          n_checks++;
          if ({data_22_s3_g, data_11_s3_g, data_00_s3_g, data_20_s3_g, data_02_s3_g}
              !== {12'd7, 12'd5, 12'd3, 12'd5, 12'd5}) begin
            n_errors++;
            $display("FAIL interior: got 22=%0d 11=%0d 00=%0d 20=%0d 02=%0d expected 7 5 3 5 5",
                     data_22_s3_g, data_11_s3_g, data_00_s3_g, data_20_s3_g, data_02_s3_g);
          end
        end
        if (y == 5 && x == 1) begin
          e = '0; e[2] = 12'd3; e[5] = 12'd4; e[8] = 12'd5;
          n_checks++;
          if (dut_window() !== e) begin
            n_errors++;
            $display("FAIL left_edge: got %h expected %h", dut_window(), e);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        step(1'b0, HA, y, '0);
        n_checks++;
        if (dut_window() !== exp_now) begin
          n_errors++;
          $display("FAIL ramp_blank y=%0d: got %h expected %h", y, dut_window(), exp_now);
        end
      end
    end
  endtask

  task automatic test_de_gap();
    win_t held;
    int y = 6;
    for (int x = 0; x < 100; x++) begin
      step(1'b1, x, y, ramp(x, y));
      n_checks++;
      if (dut_window() !== exp_now) begin
        n_errors++;
        $display("FAIL gap_lead x=%0d: got %h expected %h", x, dut_window(), exp_now);
      end
    end
    // Pixel 99 lands on the first gap cycle; from then on nothing moves.
    held = '0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 100, y, ramp(100, y));
      if (i == 0) held = dut_window();
      else begin
        n_checks++;
        if (dut_window() !== held) begin
          n_errors++;
          $display("FAIL gap_hold cycle=%0d: got %h expected %h", i, dut_window(), held);
        end
      end
      n_checks++;
      if (dut_window() !== exp_now) begin
        n_errors++;
        $display("FAIL gap_model cycle=%0d: got %h expected %h", i, dut_window(), exp_now);
      end
    end
    for (int x = 101; x < HA; x++) begin
      step(1'b1, x, y, ramp(x, y));
      n_checks++;
      if (dut_window() !== exp_now) begin
        n_errors++;
        $display("FAIL gap_tail x=%0d: got %h expected %h", x, dut_window(), exp_now);
      end
      if (x == 102) begin
        n_checks++;
        if (data_22_s3_g !== ramp(101, y)) begin
          n_errors++;
          $display("FAIL gap_resume: got %0d expected %0d", data_22_s3_g, ramp(101, y));
        end
      end
    end
    step(1'b0, HA, y, '0);
  endtask

  task automatic test_random();
    for (int y = 7; y < 10; y++) begin
      for (int x = 0; x < HA; x++) begin
        if ($urandom_range(0, 7) == 0) begin
          repeat ($urandom_range(1, 3)) begin
            step(1'b0, int'($urandom_range(0, 1023)), y, PW'($urandom));
            n_checks++;
            if (dut_window() !== exp_now) begin
              n_errors++;
              $display("FAIL random_bubble y=%0d x=%0d: got %h expected %h", y, x, dut_window(), exp_now);
            end
          end
        end
        step(1'b1, x, y, PW'($urandom_range(0, 12'hFFE)));
        n_checks++;
        if (dut_window() !== exp_now) begin
          n_errors++;
          $display("FAIL random_pix y=%0d x=%0d: got %h expected %h", y, x, dut_window(), exp_now);
        end
      end
      step(1'b0, HA, y, '0);
    end
  endtask

  task automatic test_out_of_range();
    win_t w;
    logic hit;
    for (int x = 0; x < HA; x++) step(1'b1, x, 10, PW'($urandom_range(0, 12'hFFE)));
    step(1'b1, HA, 10, 12'hFFF);
    step(1'b1, 1000, 10, 12'hFFF);
    step(1'b0, HA, 10, '0);
    for (int x = 0; x < HA + 2; x++) begin
      if (x < HA) step(1'b1, x, 11, PW'($urandom_range(0, 12'hFFE)));
      else step(1'b0, HA, 11, '0);
      w = dut_window();
      hit = 1'b0;
      for (int k = 0; k < 9; k++) if (w[k] === 12'hFFF) hit = 1'b1;
      n_checks++;
      if (hit !== 1'b0) begin
        n_errors++;
        $display("FAIL oor_leak x=%0d: got %h expected no FFF tap", x, w);
      end
      n_checks++;
      if (w !== exp_now) begin
        n_errors++;
        $display("FAIL oor_model x=%0d: got %h expected %h", x, w, exp_now);
      end
    end
  endtask

  task automatic test_reset_midline();
    int y = 12;
    for (int x = 0; x <= 300; x++) begin
      step(1'b1, x, y, PW'($urandom_range(0, 12'hFFE)));
      n_checks++;
      if (dut_window() !== exp_now) begin
        n_errors++;
        $display("FAIL mid_lead x=%0d: got %h expected %h", x, dut_window(), exp_now);
      end
    end
    step(1'b0, 301, y, '0);
    step(1'b0, 301, y, '0);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (dut_window() !== '0) begin
      n_errors++;
      $display("FAIL reset_async: got %h expected 0", dut_window());
    end
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 301, y, '0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 301, y, '0);
      n_checks++;
      if (dut_window() !== '0) begin
        n_errors++;
        $display("FAIL reset_hold cycle=%0d: got %h expected 0", i, dut_window());
      end
    end
    for (int x = 301; x < HA; x++) begin
      step(1'b1, x, y, PW'($urandom_range(0, 12'hFFE)));
      n_checks++;
      if (dut_window() !== exp_now) begin
        n_errors++;
        $display("FAIL mid_resume x=%0d: got %h expected %h", x, dut_window(), exp_now);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, HA, y, '0);
      n_checks++;
      if (dut_window() !== exp_now) begin
        n_errors++;
        $display("FAIL mid_drain: got %h expected %h", dut_window(), exp_now);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_frame();
    test_de_gap();
    test_random();
    test_out_of_range();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line and line-buffer depth.
REQ-002 Parameter PIX_W, default 12, grayscale pixel width.
REQ-003 pclk  input  1  pixel clock; all state on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 DE_s1  input  1  data enable; pixel valid this cycle.
REQ-006 x_pixel_s1  input  10  column of incoming pixel.
REQ-007 y_pixel_s1  input  10  row of incoming pixel.
REQ-008 gray_s1  input  PIX_W  incoming grayscale pixel.
REQ-009 data_00_s3_g, data_01_s3_g, data_02_s3_g  output  PIX_W each  window row 0 (line y-2), columns x-2, x-1, x.
REQ-010 data_10_s3_g, data_11_s3_g, data_12_s3_g  output  PIX_W each  window row 1 (line y-1), columns x-2, x-1, x.
REQ-011 data_20_s3_g, data_21_s3_g, data_22_s3_g  output  PIX_W each  window row 2 (line y), columns x-2, x-1, x.

Function
REQ-012 The window SHALL cover (x-2..x, y-2..y), centred on (x-1, y-1), for the pixel presented 2 cycles earlier.
REQ-013 Latency SHALL be 2 pclk cycles, so outputs align with DE_s3/x_pixel_s3/y_pixel_s3 from the s1->s2->s3 sideband registers.
REQ-014 Two line buffers SHALL be used: LB0 holds line y-1, LB1 holds line y-2, both read-first, addressed by column.
REQ-015 Cycle t with DE_s1=1 and x_pixel_s1<H_ACTIVE: read LB0[x] and LB1[x] (valid at t+1); write LB0[x]<=gray_s1.
REQ-016 Cycle t+1: write LB1[x_s2]<=LB0 read data (x_s2 = registered x); gray, x, y, DE SHALL be held in internal s2 registers.
REQ-017 Cycle t+1 with DE_s2=1: column shift col0<=col1, col1<=col2, col2<={LB1 rd, LB0 rd, gray_s2} (rows 0,1,2).
REQ-018 Left edge: when x_s2==0, col0 and col1 SHALL load 0 instead of shifting.
REQ-019 Top edge: y_s2==0 SHALL force row 0 and row 1 of the new column to 0; y_s2==1 SHALL force row 0 to 0.
REQ-020 With DE_s2=0 the window registers SHALL hold their values; no line-buffer write occurs.
REQ-021 With x_pixel_s1>=H_ACTIVE while DE_s1=1, the pixel SHALL be treated as DE=0: no read, no write, no shift.
REQ-022 Outputs SHALL be driven directly from window registers, with no combinational path from inputs.
REQ-023 No frame-start clear is needed; top-edge masking (REQ-019) hides stale line-buffer content.

Reset
REQ-024 reset_n low SHALL immediately clear all window registers and s2 registers to 0, so all nine outputs are 0.
REQ-025 Line-buffer contents SHALL NOT be reset.
REQ-026 Deassertion mid-frame SHALL resume at the next DE pixel; rows 0/1 may carry stale data until two lines are written unless y<2 masking applies. This is accepted behaviour.

Structure
REQ-027 Shared package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, PIX_W=12, COORD_W=10.
REQ-028 Sub-module line_buffer (simple dual-port, read-first, H_ACTIVE x PIX_W, synchronous read) SHALL be instantiated twice.

Verification
REQ-029 Reset: assert reset_n low mid-line -> all nine outputs 0 in the same cycle and held at 0 until the first DE pixel after release.
REQ-030 Interior, ramp gray=x+y: inject (x=5, y=2) -> 2 cycles later data_22=7, data_11=5, data_00=3, data_20=5, data_02=5.
REQ-031 Top edge, same ramp: inject (x=3, y=0) -> data_0*=0, data_1*=0, data_22=3, data_21=2, data_20=1.
REQ-032 Left edge, same ramp: inject (x=0, y=5) -> data_x0=data_x1=0 for all rows, data_02=3, data_12=4, data_22=5.
REQ-033 DE gap: hold DE low 10 cycles at x=100 mid-line -> outputs constant for all 10 cycles; resuming at x=101 gives data_22=gray(101,y).
REQ-034 Out of range: DE=1 with x=640, gray=0xFFF, then the next line -> no 0xFFF appears in any tap; line-buffer contents unchanged.
